// File: rtl/pdm_array_pkg.sv
// Shared types and constants for the PDM microphone array capture path.
//   capture_mode_t : which pdm_clk edge polarities start a column scan
//   cap_state_t    : column-scan FSM states
//   SYNC_STAGES    : depth of the clock-domain-crossing synchronisers
//   decode_mode()  : maps the raw 2-bit mode field onto capture_mode_t
package pdm_array_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        MODE_L  = 2'b00,
        MODE_R  = 2'b01,
        MODE_LR = 2'b10
    } capture_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } cap_state_t;

    // 2'b11 is folded onto stereo.
    function automatic capture_mode_t decode_mode(input logic [1:0] m);
        if (m[1]) begin
            return MODE_LR;
        end
        return m[0] ? MODE_R : MODE_L;
    endfunction

endpackage

// File: rtl/pdm_edge_sync.sv
// Multi-stage synchroniser for an asynchronous strobe, plus single-cycle rise and fall
// pulses derived from the synchronised level.
//   clk, reset_n : system clock, asynchronous active-low reset
//   async_in     : asynchronous input level
//   rise, fall   : one-cycle pulses on a 0->1 / 1->0 change of the synchronised level
module pdm_edge_sync
    import pdm_array_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/pdm_mux_array_capture.sv
// Capture front-end for the multiplexed PDM microphone array. Each qualified pdm_clk edge
// scans all mux columns: drive col_sel_ff, wait SETTLE_CYCLES, sample every row into a
// shadow frame, then hand the frame to the consumer over a valid/ready handshake.
//   clk, reset_n   : system clock, asynchronous active-low reset
//   enable         : capture enable; dropping it abandons any scan in progress
//   mode           : 00 rising only, 01 falling only, 1x both edges
//   pdm_clk        : PDM bit clock (asynchronous)
//   pdm_inp        : mux outputs, one per row (asynchronous)
//   col_sel_ff     : registered mux column select
//   frame_valid/frame_ready/frame_data/frame_side : output frame handshake
//   overrun_ff     : sticky, a completed frame was dropped
//   scan_err_ff    : sticky, a qualified edge arrived mid-scan
//   err_clr        : clears both sticky flags (wins over a same-cycle set)
module pdm_mux_array_capture
    import pdm_array_pkg::*;
#(
    parameter int unsigned NUM_ROWS      = 5,
    parameter int unsigned NUM_COLS      = 8,
    parameter int unsigned SEL_WIDTH     = $clog2(NUM_COLS),
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [1:0]                   mode,
    input  logic                         pdm_clk,
    input  logic [NUM_ROWS-1:0]          pdm_inp,
    output logic [SEL_WIDTH-1:0]         col_sel_ff,
    output logic                         frame_valid,
    input  logic                         frame_ready,
    output logic [NUM_COLS*NUM_ROWS-1:0] frame_data,
    output logic                         frame_side,
    output logic                         overrun_ff,
    output logic                         scan_err_ff,
    input  logic                         err_clr
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]     SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [SEL_WIDTH-1:0] LAST_COL    = SEL_WIDTH'(NUM_COLS - 1);

    logic                                   edge_rise;
    logic                                   edge_fall;
    logic [SYNC_STAGES-1:0][NUM_ROWS-1:0]   inp_sync_q;
    logic [NUM_COLS-1:0][NUM_ROWS-1:0]      shadow_q;
    cap_state_t                             state_q;
    capture_mode_t                          mode_q;
    capture_mode_t                          act_mode;
    logic [CNT_W-1:0]                       settle_cnt_q;
    logic                                   side_q;
    logic                                   busy;
    logic                                   qual_edge;

    pdm_edge_sync #(
        .STAGES (SYNC_STAGES)
    ) u_clk_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (pdm_clk),
        .rise     (edge_rise),
        .fall     (edge_fall)
    );

    // Mid-scan, edges are judged against the mode latched at scan start so a mode write
    // during a scan cannot fake or hide a collision.
    always_comb begin
        busy      = (state_q == SETTLE) || (state_q == SAMPLE);
        act_mode  = busy ? mode_q : decode_mode(mode);
        qual_edge = enable && ((edge_rise && (act_mode != MODE_R)) ||
                               (edge_fall && (act_mode != MODE_L)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inp_sync_q   <= '0;
            shadow_q     <= '0;
            state_q      <= IDLE;
            mode_q       <= MODE_L;
            settle_cnt_q <= '0;
            side_q       <= 1'b0;
            col_sel_ff   <= '0;
            frame_valid  <= 1'b0;
            frame_data   <= '0;
            frame_side   <= 1'b0;
            overrun_ff   <= 1'b0;
            scan_err_ff  <= 1'b0;
        end else begin
            inp_sync_q <= {inp_sync_q[SYNC_STAGES-2:0], pdm_inp};

            if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end

            // A completed frame is handed off even if enable drops in the DONE cycle.
            if (state_q == DONE) begin
                if (!frame_valid || frame_ready) begin
                    frame_data  <= shadow_q;
                    frame_side  <= side_q;
                    frame_valid <= 1'b1;
                end else begin
                    overrun_ff <= 1'b1;
                end
            end

            if (!enable) begin
                state_q    <= IDLE;
                col_sel_ff <= '0;
            end else if (qual_edge) begin
                // Start (or restart) a scan at column 0; a restart mid-scan is a collision.
                if (busy) begin
                    scan_err_ff <= 1'b1;
                end
                state_q      <= SETTLE;
                col_sel_ff   <= '0;
                settle_cnt_q <= SETTLE_LOAD;
                side_q       <= edge_fall;
                mode_q       <= decode_mode(mode);
            end else begin
                unique case (state_q)
                    IDLE: ;
                    SETTLE: begin
                        settle_cnt_q <= settle_cnt_q - CNT_W'(1);
                        if (settle_cnt_q <= CNT_W'(1)) begin
                            state_q <= SAMPLE;
                        end
                    end
                    SAMPLE: begin
                        shadow_q[col_sel_ff] <= inp_sync_q[SYNC_STAGES-1];
                        if (col_sel_ff == LAST_COL) begin
                            state_q <= DONE;
                        end else begin
                            col_sel_ff   <= col_sel_ff + SEL_WIDTH'(1);
                            settle_cnt_q <= SETTLE_LOAD;
                            state_q      <= SETTLE;
                        end
                    end
                    DONE: state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end

            if (err_clr) begin
                overrun_ff  <= 1'b0;
                scan_err_ff <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pdm_mux_array_capture.sv
// Directed bench for pdm_mux_array_capture. A behavioural analog mux drives pdm_inp from a
// per-column pattern selected by col_sel_ff; expected frames are queued as each scan is
// launched and compared whenever the DUT hands a frame over.
module tb_pdm_mux_array_capture;

    localparam int unsigned NR = 5;
    localparam int unsigned NC = 8;
    localparam int unsigned SW = 3;
    // 2 synchroniser edges, the edge cycle, 8 columns x 3 cycles, the DONE cycle.
    localparam int LATENCY = 2 + 1 + 24 + 1;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 enable;
    logic [1:0]           mode;
    logic                 pdm_clk;
    logic [NR-1:0]        pdm_inp;
    logic [SW-1:0]        col_sel_ff;
    logic                 frame_valid;
    logic                 frame_ready;
    logic [NC*NR-1:0]     frame_data;
    logic                 frame_side;
    logic                 overrun_ff;
    logic                 scan_err_ff;
    logic                 err_clr;

    logic [NR-1:0]        col_pat [NC];
    logic [NC*NR:0]       exp_q [$];
    int                   tests = 0;
    int                   failed = 0;
    int                   frames_seen = 0;

    always #5 clk = ~clk;

    assign pdm_inp = col_pat[col_sel_ff];

    pdm_mux_array_capture dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .mode        (mode),
        .pdm_clk     (pdm_clk),
        .pdm_inp     (pdm_inp),
        .col_sel_ff  (col_sel_ff),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .frame_side  (frame_side),
        .overrun_ff  (overrun_ff),
        .scan_err_ff (scan_err_ff),
        .err_clr     (err_clr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_pat(input int seed);
        for (int c = 0; c < NC; c++) begin
            col_pat[c] = NR'((c * 7 + seed) & 31);
        end
    endtask

    function automatic logic [NC*NR-1:0] exp_frame();
        logic [NC*NR-1:0] f;
        for (int c = 0; c < NC; c++) begin
            for (int r = 0; r < NR; r++) begin
                f[c*NR+r] = col_pat[c][r];
            end
        end
        return f;
    endfunction

    task automatic push_exp(input logic side);
        exp_q.push_back({side, exp_frame()});
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (frame_valid !== 1'b1 && n < 100);
    endtask

    task automatic wait_col(input logic [SW-1:0] v, input string tag);
        int n = 0;
        while (col_sel_ff !== v && n < 100) begin
            tick(1);
            n++;
        end
        check(tag, 64'(col_sel_ff), 64'(v));
    endtask

    // Scoreboard: every accepted frame must match the oldest launched scan.
    always @(negedge clk) begin
        if (reset_n && frame_valid && frame_ready) begin
            frames_seen++;
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $error("FAIL unexpected_frame: observed side %0d data 0x%0h expected none",
                       frame_side, frame_data);
            end else begin
                check("frame_out", 64'({frame_side, frame_data}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int n;
        int base;

        reset_n     = 1'b0;
        enable      = 1'b0;
        mode        = 2'b00;
        pdm_clk     = 1'b0;
        frame_ready = 1'b1;
        err_clr     = 1'b0;
        set_pat(0);
        tick(3);
        check("rst_col_sel", 64'(col_sel_ff), 64'd0);
        check("rst_flags", 64'({frame_valid, frame_side, overrun_ff, scan_err_ff}), 64'd0);
        check("rst_data", 64'(frame_data), 64'd0);
        reset_n = 1'b1;
        tick(3);

        // Basic left capture: column c carries value c.
        enable = 1'b1;
        for (int c = 0; c < NC; c++) col_pat[c] = NR'(c);
        push_exp(1'b0);
        pdm_clk = 1'b1;
        wait_valid(n);
        check("basic_latency", 64'(n), 64'(LATENCY));
        check("basic_data", 64'(frame_data), 64'(exp_frame()));
        check("basic_side", 64'(frame_side), 64'd0);
        tick(1);
        check("basic_valid_1cyc", 64'(frame_valid), 64'd0);
        tick(10);
        base = frames_seen;
        pdm_clk = 1'b0;
        tick(12);
        check("basic_no_fall_scan", 64'(col_sel_ff), 64'(NC - 1));
        tick(30);
        check("basic_no_fall_frame", 64'(frames_seen - base), 64'd0);

        // Stereo: 80-clk pdm_clk period, alternating sides.
        mode = 2'b10;
        set_pat(3);
        base = frames_seen;
        for (int e = 0; e < 4; e++) begin
            push_exp(e[0]);
            pdm_clk = ~pdm_clk;
            tick(40);
        end
        check("stereo_frames", 64'(frames_seen - base), 64'd4);
        check("stereo_flags", 64'({overrun_ff, scan_err_ff}), 64'd0);

        // Backpressure: hold first frame, drop second.
        mode = 2'b00;
        frame_ready = 1'b0;
        set_pat(11);
        push_exp(1'b0);
        pdm_clk = 1'b1;
        tick(40);
        check("bp_first_valid", 64'(frame_valid), 64'd1);
        pdm_clk = 1'b0;
        tick(40);
        set_pat(20);
        pdm_clk = 1'b1;
        tick(40);
        set_pat(11);
        check("bp_held_data", 64'(frame_data), 64'(exp_frame()));
        check("bp_held_valid", 64'(frame_valid), 64'd1);
        check("bp_overrun", 64'(overrun_ff), 64'd1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("bp_err_clr", 64'(overrun_ff), 64'd0);
        base = frames_seen;
        frame_ready = 1'b1;
        tick(2);
        check("bp_drain", 64'(frames_seen - base), 64'd1);
        check("bp_valid_low", 64'(frame_valid), 64'd0);

        // Collision: 15-clk half period is shorter than a scan.
        mode = 2'b10;
        base = frames_seen;
        for (int e = 0; e < 6; e++) begin
            pdm_clk = ~pdm_clk;
            tick(3);
            check("coll_col_restart", 64'(col_sel_ff), 64'd0);
            tick(12);
        end
        enable = 1'b0;
        tick(40);
        check("coll_scan_err", 64'(scan_err_ff), 64'd1);
        check("coll_no_frame", 64'(frames_seen - base), 64'd0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("coll_err_clr", 64'(scan_err_ff), 64'd0);

        // Enable drop mid-scan at column 4.
        mode = 2'b00;
        pdm_clk = 1'b0;
        tick(5);
        enable = 1'b1;
        tick(2);
        set_pat(5);
        base = frames_seen;
        pdm_clk = 1'b1;
        wait_col(3'd4, "en_reach_col4");
        enable = 1'b0;
        tick(1);
        check("en_col_reset", 64'(col_sel_ff), 64'd0);
        tick(40);
        check("en_no_frame", 64'(frames_seen - base), 64'd0);
        enable = 1'b1;
        pdm_clk = 1'b0;
        tick(10);
        set_pat(9);
        push_exp(1'b0);
        pdm_clk = 1'b1;
        tick(40);
        check("en_refill_frame", 64'(frames_seen - base), 64'd1);

        // Asynchronous reset at column 5.
        pdm_clk = 1'b0;
        tick(10);
        base = frames_seen;
        set_pat(17);
        pdm_clk = 1'b1;
        wait_col(3'd5, "rst_reach_col5");
        reset_n = 1'b0;
        #1;
        check("arst_col_sel", 64'(col_sel_ff), 64'd0);
        check("arst_flags", 64'({frame_valid, frame_side, overrun_ff, scan_err_ff}), 64'd0);
        check("arst_data", 64'(frame_data), 64'd0);
        pdm_clk = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(5);
        check("arst_after_release", 64'({col_sel_ff, frame_valid}), 64'd0);
        set_pat(23);
        push_exp(1'b0);
        pdm_clk = 1'b1;
        wait_valid(n);
        check("arst_recapture_latency", 64'(n), 64'(LATENCY));
        tick(5);
        check("arst_frames", 64'(frames_seen - base), 64'd1);

        check("total_frames", 64'(frames_seen), 64'd8);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pdm_mux_array_capture.md
Name: pdm_mux_array_capture

Overview:
Next-generation capture front-end for the multiplexed PDM microphone array.
- Each pdm_clk edge of the selected polarity starts a column scan. The block drives the analog-mux select and waits a programmable settle time per column. It then samples all rows of that column into a shadow frame.
- Supports left-only, right-only or stereo (both edges) capture.
- Completed frames go out through a valid/ready handshake, with overrun and scan-collision error flags.
- Sits between the array shield pins and the per-channel CIC decimators.

Parameters:
- NUM_ROWS, 5: PDM data lines (rows) into the block.
- NUM_COLS, 8: mux columns per scan.
- SEL_WIDTH, $clog2(NUM_COLS): width of the column select.
- SETTLE_CYCLES, 2: clk cycles between a select change and the sample. Must be ≥1 and must cover mux delay plus the 2-stage pdm_inp synchroniser.

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous, active-low reset.
- enable, in, 1: capture enable.
- mode, in, 2: 00 = rising edge only (L); 01 = falling edge only (R); 10 = both edges; 11 = treated as 10.
- pdm_clk, in, 1: PDM bit clock (asynchronous to clk).
- pdm_inp, in, NUM_ROWS: mux outputs, one per row.
- col_sel_ff, out, SEL_WIDTH: registered mux column select.
- frame_valid, out, 1: output frame available.
- frame_ready, in, 1: consumer accepts the frame.
- frame_data, out, NUM_COLS*NUM_ROWS: bit [c*NUM_ROWS+r] = column c, row r.
- frame_side, out, 1: 0 = rising-edge (L) frame, 1 = falling-edge (R) frame.
- overrun_ff, out, 1: sticky; a frame was dropped.
- scan_err_ff, out, 1: sticky; a new edge arrived mid-scan.
- err_clr, in, 1: clears both sticky flags.

Behaviour:
- Reset values of all outputs: col_sel_ff=0, frame_valid=0, frame_data=0, frame_side=0, overrun_ff=0, scan_err_ff=0. FSM resets to IDLE.
- Synchronisation:
  - pdm_clk passes through a 2-FF synchroniser plus a registered copy. A rise or fall of the synchronised level produces a 1-cycle edge pulse.
  - pdm_inp passes through a 2-FF synchroniser.
- Qualified edge: an edge pulse whose polarity matches mode, while enable=1. mode is latched at the qualified edge. frame_side is set from the edge polarity.
- FSM states:
  - IDLE: on a qualified edge, set col_sel_ff=0, load settle_cnt=SETTLE_CYCLES, go to SETTLE.
  - SETTLE: decrement settle_cnt each cycle. At 0, go to SAMPLE.
  - SAMPLE (1 cycle): write shadow[col_sel_ff] = synchronised pdm_inp.
    - If col_sel_ff == NUM_COLS-1, go to DONE.
    - Otherwise increment col_sel_ff, reload settle_cnt, go to SETTLE.
  - DONE (1 cycle): hand off the shadow frame (see Handshake), then go to IDLE.
- Per-column cost is SETTLE_CYCLES+1 cycles. Scan length is NUM_COLS*(SETTLE_CYCLES+1) cycles from the edge pulse to DONE. frame_valid rises the cycle after DONE.
- Handshake:
  - In DONE, if frame_valid=0 or (frame_valid & frame_ready), load frame_data/frame_side from the shadow and set frame_valid=1.
  - Otherwise discard the shadow frame and set overrun_ff=1.
  - frame_valid & frame_ready with no load pending clears frame_valid.
  - frame_data and frame_side are stable while frame_valid=1.
- Collision: a qualified edge in SETTLE or SAMPLE aborts the current scan. Set scan_err_ff=1 and restart at column 0 with the new side. The partial frame is never output.
- A qualified edge in the DONE cycle completes the handoff and starts the new scan directly; this is not an error.
- enable=0: FSM goes to IDLE next cycle, col_sel_ff=0, and any partial scan is discarded. A pending output frame stays valid until accepted.
- err_clr has priority over a same-cycle set. Both flags read 0 the next cycle.
- Asynchronous reset mid-scan: everything returns to reset values immediately. No frame is output.

Decomposition:
- Shared package pdm_array_pkg:
  - capture_mode_t enum (MODE_L, MODE_R, MODE_LR).
  - cap_state_t enum (IDLE, SETTLE, SAMPLE, DONE).
  - SYNC_STAGES=2.
- One sub-module, pdm_edge_sync: 2-FF synchroniser plus rise/fall pulse generation for pdm_clk. Reused for other asynchronous strobes.

Test Plan (NUM_ROWS=5, NUM_COLS=8, SETTLE_CYCLES=2, scan = 24 cycles):
- Basic L capture: mode=00, frame_ready=1, column c drives pdm_inp=c[4:0] while col_sel_ff=c, one pdm_clk rise → frame_valid=1 for one cycle, 25 cycles after the edge pulse. frame_data column c = c, frame_side=0. No capture on the fall.
- Stereo: mode=10, pdm_clk period 80 clk → alternating frames with frame_side 0,1,0,1. No error flags.
- Backpressure: frame_ready=0 across two L scans → first frame held unchanged. Second frame dropped, overrun_ff=1. err_clr pulse → overrun_ff=0 next cycle.
- Collision: mode=10, pdm_clk half-period 15 clk (< 24-cycle scan) → scan_err_ff=1, no frame_valid ever asserted, col_sel_ff returns to 0 at each edge.
- enable drop: deassert enable at column 4 of a scan → col_sel_ff=0 next cycle, no frame. Re-enable; next rise yields a correct full frame.
- Reset mid-scan: reset_n low at column 5 → all outputs 0 immediately. Edges after release capture normally.
